// File: rtl/grey_seq_ctrl.sv
// Sequencer for a chain of grey-code decade digits: count strobes, carry ripple and reset/flush handshake.
// Optional GREY_SEQ_STATUS_EN adds o_inc_total, a saturating count of completed increments.
module grey_seq_ctrl #(
    parameter int pDIGITS  = 4,
    parameter int pPULSE_W = 2,
    parameter int pLOW_W   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_inc,
    input  logic               i_clr,
    input  logic [pDIGITS-1:0] i_roll,
    output logic               o_rst,
    output logic [pDIGITS-1:0] o_cnt,
    output logic               o_busy,
    output logic               o_ack,
`ifdef GREY_SEQ_STATUS_EN
    output logic [15:0]        o_inc_total,
`endif
    output logic               o_ovf
);

    localparam int DW   = (pDIGITS > 1) ? $clog2(pDIGITS) : 1;
    localparam int MAXW = (pPULSE_W > pLOW_W) ? pPULSE_W : pLOW_W;
    localparam int CW   = $clog2(MAXW + 1);
    localparam logic [DW-1:0] LAST_D = DW'(pDIGITS - 1);
    localparam logic [CW-1:0] HI_END = CW'(pPULSE_W - 1);
    localparam logic [CW-1:0] LO_END = CW'(pLOW_W - 1);

    typedef enum logic [2:0] {
        RST_HOLD, FLUSH_HI, FLUSH_LO, RELEASE, IDLE, INC_HI, INC_LO, DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cyc;
    logic [DW-1:0]      d, d_nxt;
    logic               pend_inc, pend_inc_nxt;
    logic               pend_clr, pend_clr_nxt;
    logic               clr_seq, clr_seq_nxt;
    logic               ovf_nxt, ack_nxt, last;
    logic [pDIGITS-1:0] cnt_nxt;

    always_comb begin
        state_nxt    = state;
        d_nxt        = d;
        pend_inc_nxt = pend_inc;
        pend_clr_nxt = pend_clr;
        clr_seq_nxt  = clr_seq;
        ovf_nxt      = o_ovf;
        ack_nxt      = 1'b0;
        cnt_nxt      = '0;
        last = (state == FLUSH_HI || state == INC_HI) ? (cyc == HI_END) : (cyc == LO_END);

        // Requests arriving while busy park in one-deep latches; repeats are absorbed.
        if (state != IDLE) begin
            pend_inc_nxt = pend_inc | i_inc;
            pend_clr_nxt = pend_clr | i_clr;
        end

        case (state)
            RST_HOLD: if (last) state_nxt = FLUSH_HI;
            FLUSH_HI: if (last) state_nxt = FLUSH_LO;
            FLUSH_LO: if (last) state_nxt = RELEASE;
            RELEASE: begin
                if (last) begin
                    state_nxt = IDLE;
                    if (clr_seq) begin
                        ack_nxt     = 1'b1;
                        ovf_nxt     = 1'b0;
                        clr_seq_nxt = 1'b0;
                    end
                end
            end
            IDLE: begin
                if (i_clr || pend_clr) begin
                    state_nxt    = RST_HOLD;
                    pend_clr_nxt = 1'b0;
                    clr_seq_nxt  = 1'b1;
                    pend_inc_nxt = pend_inc | i_inc;
                end else if (i_inc || pend_inc) begin
                    state_nxt    = INC_HI;
                    d_nxt        = '0;
                    pend_inc_nxt = 1'b0;
                end
            end
            INC_HI: if (last) state_nxt = INC_LO;
            INC_LO: begin
                if (last) begin
                    if (i_roll[d] && d != LAST_D) begin
                        d_nxt     = d + DW'(1);
                        state_nxt = INC_HI;
                    end else begin
                        if (i_roll[d]) ovf_nxt = 1'b1;
                        state_nxt = DONE;
                        ack_nxt   = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = RST_HOLD;
        endcase

        // Strobes are decoded from the next state so the output registers carry them glitch-free.
        if (state_nxt == FLUSH_HI)
            cnt_nxt = '1;
        else if (state_nxt == INC_HI)
            cnt_nxt[d_nxt] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= RST_HOLD;
            cyc      <= '0;
            d        <= '0;
            pend_inc <= 1'b0;
            pend_clr <= 1'b0;
            clr_seq  <= 1'b0;
            o_rst    <= 1'b1;
            o_cnt    <= '0;
            o_busy   <= 1'b1;
            o_ack    <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cyc      <= (state_nxt != state) ? '0 : cyc + CW'(1);
            d        <= d_nxt;
            pend_inc <= pend_inc_nxt;
            pend_clr <= pend_clr_nxt;
            clr_seq  <= clr_seq_nxt;
            o_rst    <= (state_nxt == RST_HOLD) || (state_nxt == FLUSH_HI) || (state_nxt == FLUSH_LO);
            o_cnt    <= cnt_nxt;
            o_busy   <= (state_nxt != IDLE);
            o_ack    <= ack_nxt;
            o_ovf    <= ovf_nxt;
        end
    end

`ifdef GREY_SEQ_STATUS_EN
    logic clr_done, inc_done;
    assign clr_done = (state == RELEASE) && last && clr_seq;
    assign inc_done = (state == INC_LO) && (state_nxt == DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst || clr_done)
            o_inc_total <= '0;
        else if (inc_done && o_inc_total != 16'hFFFF)
            o_inc_total <= o_inc_total + 16'd1;
    end
`endif

endmodule

// File: tb/tb_grey_seq_ctrl.sv
// Self-checking bench for grey_seq_ctrl with behavioural decade-digit models on the strobe outputs.
module tb_grey_seq_ctrl;

    localparam int ND    = 4;
    localparam int PW    = 2;
    localparam int LW    = 2;
    localparam int T_CLR = 1 + 3 * LW + PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inc = 1'b0;
    logic          clr = 1'b0;
    logic [ND-1:0] roll_v = '0;
    logic          o_rst, o_busy, o_ack, o_ovf;
    logic [ND-1:0] o_cnt;
`ifdef GREY_SEQ_STATUS_EN
    logic [15:0]   o_inc_total;
`endif

    always #5 clk = ~clk;

    grey_seq_ctrl #(.pDIGITS(ND), .pPULSE_W(PW), .pLOW_W(LW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_inc(inc),
        .i_clr(clr),
        .i_roll(roll_v),
        .o_rst(o_rst),
        .o_cnt(o_cnt),
        .o_busy(o_busy),
        .o_ack(o_ack),
`ifdef GREY_SEQ_STATUS_EN
        .o_inc_total(o_inc_total),
`endif
        .o_ovf(o_ovf)
    );

    int nvec = 0;
    int nfail = 0;

    int            dig[ND] = '{default: 3};
    int            strobe_tot[ND] = '{default: 0};
    logic [ND-1:0] cnt_prev = '0;
    bit            load_req = 1'b0;
    int            load_val = 0;

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r *= 10;
        return r;
    endfunction

    function automatic int dval();
        int r = 0;
        for (int i = 0; i < ND; i++) r += dig[i] * p10(i);
        return r;
    endfunction

    // Digit models: each advances on the rising edge of its strobe, loading 0 while o_rst is held.
    always @(negedge clk) begin
        if (load_req) begin
            for (int i = 0; i < ND; i++) begin
                dig[i] = (load_val / p10(i)) % 10;
                roll_v[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < ND; i++) begin
                if (o_cnt[i] && !cnt_prev[i]) begin
                    strobe_tot[i]++;
                    if (o_rst) begin
                        dig[i] = 0;
                        roll_v[i] = 1'b0;
                    end else if (dig[i] == 9) begin
                        dig[i] = 0;
                        roll_v[i] = 1'b1;
                    end else begin
                        dig[i]++;
                        roll_v[i] = 1'b0;
                    end
                end
            end
        end
        cnt_prev = o_cnt;
        if (!o_rst && $countones(o_cnt) > 1) begin
            nfail++;
            $display("FAIL onehot: o_cnt=%b with o_rst low, required at most one bit", o_cnt);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic preload(input int v);
        load_val = v;
        load_req = 1'b1;
        @(negedge clk);
        #1 load_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("idle_timeout", n, 0);
    endtask

    task automatic do_op(input bit do_inc, input bit do_clr, output int lat);
        wait_idle();
        inc = do_inc;
        clr = do_clr;
        @(posedge clk);
        #1;
        inc = 1'b0;
        clr = 1'b0;
        lat = 1;
        while (!o_ack && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) chk("ack_timeout", lat, 0);
    endtask

    task automatic run_check(input string tag, input bit is_clr, input int exp_val,
                             input int exp_lat, input bit exp_ovf, input int exp_enc);
        int snap[ND];
        int lat, enc;
        wait_idle();
        for (int i = 0; i < ND; i++) snap[i] = strobe_tot[i];
        do_op(!is_clr, is_clr, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_ovf"}, int'(o_ovf), int'(exp_ovf));
        @(posedge clk);
        #1;
        chk({tag, "_ackw"}, int'(o_ack), 0);
        enc = 0;
        for (int i = 0; i < ND; i++) enc += (strobe_tot[i] - snap[i]) * p10(i);
        chk({tag, "_strb"}, enc, exp_enc);
        chk({tag, "_val"}, dval(), exp_val);
    endtask

    typedef struct {
        int start;
        bit is_clr;
        int exp_val;
        int exp_lat;
        bit exp_ovf;
        int exp_enc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int nr, nf, nb, na, lat, t, acks, a1, a2, mval, n, v, kk, exp_enc;
        bit movf, op_clr;

        vecs[0] = '{0,    1'b0, 1,    5,  1'b0, 1};
        vecs[1] = '{9,    1'b0, 10,   9,  1'b0, 11};
        vecs[2] = '{99,   1'b0, 100,  13, 1'b0, 111};
        vecs[3] = '{999,  1'b0, 1000, 17, 1'b0, 1111};
        vecs[4] = '{1234, 1'b0, 1235, 5,  1'b0, 1};
        vecs[5] = '{9899, 1'b0, 9900, 13, 1'b0, 111};
        vecs[6] = '{9999, 1'b0, 0,    17, 1'b1, 1111};
        vecs[7] = '{4567, 1'b0, 4568, 5,  1'b1, 1};
        vecs[8] = '{5,    1'b1, 0,    9,  1'b0, 1111};

        // Power-on reset and flush
        preload(7777);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_rst", int'(o_rst), 1);
        chk("rst_o_cnt", int'(o_cnt), 0);
        chk("rst_o_busy", int'(o_busy), 1);
        chk("rst_o_ack", int'(o_ack), 0);
        chk("rst_o_ovf", int'(o_ovf), 0);
        rst = 1'b0;
        nr = 0; nf = 0; nb = 0; na = 0;
        repeat (20) begin
            @(negedge clk);
            nr += o_rst ? 1 : 0;
            nf += (o_cnt == 4'b1111) ? 1 : 0;
            nb += o_busy ? 1 : 0;
            na += o_ack ? 1 : 0;
        end
        chk("rst_hi_cycles", nr, 2 * LW + PW + LW - LW);
        chk("flush_cycles", nf, PW);
        chk("busy_after_rst", nb - nr, LW);
        chk("rst_no_ack", na, 0);
        chk("rst_digits", dval(), 0);

        @(posedge clk);
        #1;
        repeat (99) do_op(1'b1, 1'b0, lat);
        chk("inc99_val", dval(), 99);

        for (int i = 0; i < 9; i++) begin
            wait_idle();
            preload(vecs[i].start);
            run_check($sformatf("vec%0d", i), vecs[i].is_clr, vecs[i].exp_val,
                      vecs[i].exp_lat, vecs[i].exp_ovf, vecs[i].exp_enc);
        end

        // Simultaneous clear and increment, with a third increment dropped
        wait_idle();
        preload(5);
        inc = 1'b1; clr = 1'b1;
        @(posedge clk);
        #1;
        inc = 1'b0; clr = 1'b0;
        t = 1; acks = 0; a1 = 0; a2 = 0;
        while (t < 60) begin
            if (o_ack) begin
                acks++;
                if (acks == 1) a1 = t;
                else if (acks == 2) a2 = t;
            end
            inc = (t == 3);
            @(posedge clk);
            #1;
            t++;
        end
        inc = 1'b0;
        chk("sim_acks", acks, 2);
        chk("sim_ack1", a1, T_CLR);
        chk("sim_ack2", a2, T_CLR + 1 + PW + LW);
        chk("sim_val", dval(), 1);

        // Clear latched during an increment runs after the increment acks
        wait_idle();
        preload(42);
        inc = 1'b1;
        @(posedge clk);
        #1;
        inc = 1'b0;
        t = 1; acks = 0; a1 = 0; a2 = 0;
        while (t < 60) begin
            if (o_ack) begin
                acks++;
                if (acks == 1) a1 = t;
                else if (acks == 2) a2 = t;
            end
            clr = (t == 2);
            @(posedge clk);
            #1;
            t++;
        end
        clr = 1'b0;
        chk("pclr_acks", acks, 2);
        chk("pclr_ack1", a1, 5);
        chk("pclr_ack2", a2, 6 + T_CLR);
        chk("pclr_val", dval(), 0);

        // Reset during the digit-1 strobe, with a clear already latched
        wait_idle();
        preload(9);
        inc = 1'b1;
        @(posedge clk);
        #1;
        inc = 1'b0;
        for (t = 1; t < 5; t++) begin
            clr = (t == 2);
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        chk("abort_pre_cnt", int'(o_cnt), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_cnt", int'(o_cnt), 0);
        chk("abort_rst", int'(o_rst), 1);
        chk("abort_busy", int'(o_busy), 1);
        chk("abort_ack", int'(o_ack), 0);
        na = 0;
        repeat (40) begin
            @(negedge clk);
            na += o_ack ? 1 : 0;
        end
        chk("abort_no_pending", na, 0);
        chk("abort_idle", int'(o_busy), 0);
        chk("abort_val", dval(), 0);

        // Randomized operations against a decimal-counter reference
        mval = 0;
        movf = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 60; k++) begin
            wait_idle();
            v = $urandom_range(0, 9);
            op_clr = (v == 0);
            if (v >= 7) begin
                v = $urandom_range(0, 9999);
                kk = $urandom_range(1, 4);
                v = (v / p10(kk)) * p10(kk) + p10(kk) - 1;
                preload(v);
                mval = v;
            end
            if (op_clr) begin
                mval = 0;
                movf = 1'b0;
                run_check($sformatf("rnd%0d", k), 1'b1, mval, T_CLR, movf, 1111);
            end else begin
                n = 1;
                v = mval;
                while (v % 10 == 9 && n < ND) begin
                    n++;
                    v = v / 10;
                end
                exp_enc = 0;
                for (int i = 0; i < n; i++) exp_enc += p10(i);
                if (mval == 9999) movf = 1'b1;
                mval = (mval + 1) % 10000;
                run_check($sformatf("rnd%0d", k), 1'b0, mval, 1 + n * (PW + LW), movf, exp_enc);
            end
        end

`ifdef GREY_SEQ_STATUS_EN
        do_op(1'b0, 1'b1, lat);
        repeat (3) do_op(1'b1, 1'b0, lat);
        @(posedge clk);
        #1;
        chk("inc_total", int'(o_inc_total), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/grey_seq_ctrl.md
Name: grey_seq_ctrl

Overview:
Sequencer for a chain of pDIGITS grey-code decade digit counters, each clocked by its own count strobe. It converts single-cycle increment and clear requests on i_clk into correctly timed count strobes and carry ripple. It also runs the digits' reset/flush handshake, in which each digit loads its initial value on a count edge while its reset is held. Sits between the host logic and the digit chain: it drives every digit's i_rst and i_cnt and reads every digit's o_roll.

Parameters:
pDIGITS, 4, number of cascaded decade digits (1..8)
pPULSE_W, 2, cycles each count strobe is held high (>=1)
pLOW_W, 2, cycles of low/settle time after each strobe and in the reset phases (>=1)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_inc  input  1  increment request, one-cycle pulse
i_clr  input  1  clear request, one-cycle pulse; re-runs the digit reset sequence
i_roll  input  pDIGITS  o_roll of each digit, bit 0 = least significant digit
o_rst  output  1  reset to all digits
o_cnt  output  pDIGITS  count strobe per digit
o_busy  output  1  high in every state except IDLE
o_ack  output  1  one-cycle pulse when an increment or clear completes
o_ovf  output  1  sticky flag: the most significant digit rolled

Behaviour:
- Reset is i_rst, synchronous, active-high, clock i_clk.
- While i_rst is high: o_rst=1, o_cnt=0, o_busy=1, o_ack=0, o_ovf=0, pending flag=0, digit index=0. On release the FSM starts in RST_HOLD.
- States and transitions:
  - RST_HOLD: o_rst=1, o_cnt=0 for pLOW_W cycles, then go to FLUSH_HI.
  - FLUSH_HI: o_rst=1, o_cnt=all ones for pPULSE_W cycles. Digits load their init value and clear roll.
  - FLUSH_LO: o_rst=1, o_cnt=0 for pLOW_W cycles.
  - RELEASE: o_rst=0 for pLOW_W cycles. Then go to IDLE. o_ack pulses on entry to IDLE only if the sequence came from i_clr.
  - IDLE: o_busy=0.
    - i_clr (or pending clear): go to RST_HOLD.
    - else i_inc (or pending inc): set d=0, go to INC_HI.
  - INC_HI: o_cnt[d]=1, all other bits 0, for pPULSE_W cycles.
  - INC_LO: o_cnt=0 for pLOW_W cycles. Sample i_roll[d] in the last cycle:
    - roll=1 and d<pDIGITS-1: d<=d+1, go to INC_HI.
    - roll=1 and d=pDIGITS-1: set o_ovf, go to DONE.
    - roll=0: go to DONE.
  - DONE: o_ack=1 for one cycle, then go to IDLE.
- Latency: i_inc accepted in IDLE at cycle t, no carry: o_cnt[0] high t+1..t+pPULSE_W. o_ack at t+1+pPULSE_W+pLOW_W (t+5 at defaults). Each carry adds pPULSE_W+pLOW_W cycles.
- Pending requests: one-deep latch each for inc and clr, captured while o_busy=1. Further requests while a latch is set are dropped.
- Simultaneous i_clr and i_inc: clear wins; the inc is latched as pending and serviced after the clear.
- Pending clear set during an increment: the increment finishes (its ack included), then the clear runs.
- Only one o_cnt bit is ever high outside FLUSH_HI. o_cnt and o_rst are registered outputs (glitch-free strobes).
- o_ovf is cleared only by i_rst or by completion of a clear sequence.
- i_rst mid-sequence aborts immediately to the reset values above. A strobe in progress is cut short.

Optional Feature:
Macro GREY_SEQ_STATUS_EN.
- Defined: adds output o_inc_total (16 bits). It increments by 1 on each increment o_ack, saturates at 16'hFFFF, and is zeroed by i_rst or clear completion.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: i_rst high 3 cycles, then low, with digit models attached -> o_rst high through RST_HOLD+FLUSH (2+2+2 cycles at defaults), o_cnt=4'b1111 for exactly 2 cycles, o_busy falls 2 cycles after o_rst falls, all digits read value 0, o_ack stays 0.
- Single inc from 0000 -> only o_cnt[0] pulses, 2 cycles wide; o_ack at t+5; digits read 0001.
- Carry: preload digits to 0099 with 99 incs, then one inc -> o_cnt[0], o_cnt[1], o_cnt[2] each pulse once in that order; digits read 0100; o_ack at t+13.
- Overflow: from 9999, one inc -> four strobes, digits read 0000, o_ovf=1 and stays 1. Then i_clr -> flush sequence runs, o_ack pulses, o_ovf=0.
- Simultaneous i_clr+i_inc in IDLE from 0005 -> clear runs first, then the pending inc; final value 0001 with two o_ack pulses. A third i_inc issued while the pending inc is latched is dropped.
- i_rst asserted during INC_HI of digit 1 -> next cycle o_cnt=0, o_rst=1, o_busy=1, pending flags cleared.
